// File: rtl/cla_adder.sv
// rtl/cla_adder.sv - registered two-level carry-lookahead adder (optional subtract via CLA_SUB_EN)
module cla_adder #(
    parameter int WIDTH = 2,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef CLA_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             p_out,
    output logic             g_out
);

    localparam int NG = (WIDTH + GROUP - 1) / GROUP;

    logic [WIDTH-1:0] bx;
    logic             c0;
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH:0]   c;
    logic [NG-1:0]    gg;
    logic [NG-1:0]    gp;
    logic [NG:0]      gc;
    logic             blk_g;
    logic             blk_p;

`ifdef CLA_SUB_EN
    assign bx = b ^ {WIDTH{sub}};
    assign c0 = cin ^ sub;
`else
    assign bx = b;
    assign c0 = cin;
`endif

    assign g = a & bx;
    assign p = a ^ bx;

    always_comb begin
        logic prod;
        prod  = 1'b1;
        gg    = '0;
        gp    = '1;
        gc    = '0;
        c     = '0;
        blk_g = 1'b0;
        blk_p = 1'b1;
        // group generate/propagate, independent of any carry-in
        for (int k = 0; k < NG; k++) begin
            for (int j = 0; j < GROUP; j++) begin
                if (k * GROUP + j < WIDTH) begin
                    gg[k] = g[k*GROUP+j] | (p[k*GROUP+j] & gg[k]);
                    gp[k] = gp[k] & p[k*GROUP+j];
                end
            end
        end
        // second level: every group carry-in is a flat sum of products over lower groups
        for (int k = 0; k <= NG; k++) begin
            prod = 1'b1;
            for (int m = k - 1; m >= 0; m--) begin
                gc[k] = gc[k] | (gg[m] & prod);
                prod  = prod & gp[m];
            end
            if (k == NG) begin
                blk_g = gc[k];
                blk_p = prod;
            end
            gc[k] = gc[k] | (prod & c0);
        end
        for (int k = 0; k < NG; k++) begin
            c[k*GROUP] = gc[k];
        end
        c[WIDTH] = gc[NG];
        // carries inside a group start from that group's lookahead carry-in
        for (int i = 0; i < WIDTH; i++) begin
            if (((i + 1) % GROUP != 0) && (i + 1 < WIDTH)) begin
                c[i+1] = g[i] | (p[i] & c[i]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            s         <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            p_out     <= 1'b0;
            g_out     <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                s     <= p ^ c[WIDTH-1:0];
                cout  <= c[WIDTH];
                ovf   <= c[WIDTH] ^ c[WIDTH-1];
                p_out <= blk_p;
                g_out <= blk_g;
            end
        end
    end

endmodule

// File: tb/tb_cla_adder.sv
// tb/tb_cla_adder.sv - bench for cla_adder at several widths/group sizes
module tb_cla_adder;

`ifdef CLA_SUB_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        cin;
    logic        sub;
    logic [63:0] a_r;
    logic [63:0] b_r;

    logic        ov1, co1, of1, po1, go1;
    logic [0:0]  s1;
    logic        ov2, co2, of2, po2, go2;
    logic [1:0]  s2;
    logic        ov7, co7, of7, po7, go7;
    logic [6:0]  s7;
    logic        ov8, co8, of8, po8, go8;
    logic [7:0]  s8;
    logic        ov13, co13, of13, po13, go13;
    logic [12:0] s13;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cla_adder #(.WIDTH(1), .GROUP(2)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a_r[0:0]), .b(b_r[0:0]), .cin(cin),
`ifdef CLA_SUB_EN
        .sub(sub),
`endif
        .out_valid(ov1), .s(s1), .cout(co1), .ovf(of1), .p_out(po1), .g_out(go1));

    cla_adder #(.WIDTH(2), .GROUP(4)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a_r[1:0]), .b(b_r[1:0]), .cin(cin),
`ifdef CLA_SUB_EN
        .sub(sub),
`endif
        .out_valid(ov2), .s(s2), .cout(co2), .ovf(of2), .p_out(po2), .g_out(go2));

    cla_adder #(.WIDTH(7), .GROUP(3)) u7 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a_r[6:0]), .b(b_r[6:0]), .cin(cin),
`ifdef CLA_SUB_EN
        .sub(sub),
`endif
        .out_valid(ov7), .s(s7), .cout(co7), .ovf(of7), .p_out(po7), .g_out(go7));

    cla_adder #(.WIDTH(8), .GROUP(4)) u8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a_r[7:0]), .b(b_r[7:0]), .cin(cin),
`ifdef CLA_SUB_EN
        .sub(sub),
`endif
        .out_valid(ov8), .s(s8), .cout(co8), .ovf(of8), .p_out(po8), .g_out(go8));

    cla_adder #(.WIDTH(13), .GROUP(4)) u13 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a_r[12:0]), .b(b_r[12:0]), .cin(cin),
`ifdef CLA_SUB_EN
        .sub(sub),
`endif
        .out_valid(ov13), .s(s13), .cout(co13), .ovf(of13), .p_out(po13), .g_out(go13));

    // packed as {out_valid, ovf, g_out, p_out, cout, s zero-extended to 13 bits}
    logic [17:0] got [5];
    assign got[0] = {ov1,  of1,  go1,  po1,  co1,  12'd0, s1};
    assign got[1] = {ov2,  of2,  go2,  po2,  co2,  11'd0, s2};
    assign got[2] = {ov7,  of7,  go7,  po7,  co7,  6'd0,  s7};
    assign got[3] = {ov8,  of8,  go8,  po8,  co8,  5'd0,  s8};
    assign got[4] = {ov13, of13, go13, po13, co13, s13};

    int wl [5] = '{1, 2, 7, 8, 13};

    // arithmetic reference: integer sum, signed range test for overflow
    function automatic logic [17:0] model(int w, logic [63:0] av_in, logic [63:0] bv_in,
                                          logic ci_in, logic sb);
        longint m, av, bv, ci, sum, sa, sbv, ss, lim;
        logic [12:0] sres;
        logic co, of, pp, gg;
        m   = (longint'(1) << w) - 1;
        av  = longint'(av_in) & m;
        bv  = (sb ? ~longint'(bv_in) : longint'(bv_in)) & m;
        ci  = longint'(ci_in ^ sb);
        sum = av + bv + ci;
        sres = 13'(sum & m);
        co  = ((sum >> w) & 1) != 0;
        lim = longint'(1) << (w - 1);
        sa  = (av >= lim) ? av - (m + 1) : av;
        sbv = (bv >= lim) ? bv - (m + 1) : bv;
        ss  = sa + sbv + ci;
        of  = (ss > lim - 1) || (ss < -lim);
        pp  = ((av ^ bv) == m);
        gg  = (((av + bv) >> w) & 1) != 0;
        return {1'b1, of, gg, pp, co, sres};
    endfunction

    task automatic check(string nm, logic [17:0] got_v, logic [17:0] exp_v);
        checks++;
        if (got_v !== exp_v) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", nm, got_v, exp_v);
        end
    endtask

    typedef struct {
        logic [1:0]  a;
        logic [1:0]  b;
        logic        cin;
        logic        vld;
        logic [17:0] exp;
    } vec_t;

    vec_t tbl [5];
    logic [17:0] exp_h [5];

    initial begin
        tbl[0] = '{a: 2'b10, b: 2'b10, cin: 1'b0, vld: 1'b1, exp: {5'b11101, 13'd0}};
        tbl[1] = '{a: 2'b01, b: 2'b10, cin: 1'b1, vld: 1'b1, exp: {5'b10011, 13'd0}};
        tbl[2] = '{a: 2'b11, b: 2'b01, cin: 1'b0, vld: 1'b1, exp: {5'b10101, 13'd0}};
        tbl[3] = '{a: 2'b11, b: 2'b01, cin: 1'b0, vld: 1'b1, exp: {5'b10101, 13'd0}};
        tbl[4] = '{a: 2'b00, b: 2'b00, cin: 1'b0, vld: 1'b0, exp: {5'b00101, 13'd0}};

        rst_n = 1'b0; in_valid = 1'b1; cin = 1'b1; sub = 1'b0;
        a_r = {$urandom, $urandom}; b_r = {$urandom, $urandom};
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 5; k++) check($sformatf("reset_w%0d", wl[k]), got[k], 18'd0);

        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            a_r = {62'd0, tbl[i].a}; b_r = {62'd0, tbl[i].b};
            cin = tbl[i].cin; in_valid = tbl[i].vld;
            @(posedge clk); #1;
            check($sformatf("table_%0d", i), got[1], tbl[i].exp);
        end

`ifdef CLA_SUB_EN
        in_valid = 1'b1; sub = 1'b1; cin = 1'b0;
        a_r = 64'h05; b_r = 64'h07;
        @(posedge clk); #1;
        check("sub_5_minus_7", got[3], {5'b10000, 13'h0FE});
        a_r = 64'h80; b_r = 64'h01;
        @(posedge clk); #1;
        check("sub_80_minus_1", got[3], {5'b11101, 13'h07F});
        sub = 1'b0;
`endif

        in_valid = 1'b1; cin = 1'b0; a_r = 64'd1; b_r = 64'd1;
        @(posedge clk); #1;
        check("pre_reset_sum", got[1], {5'b11000, 13'd2});
        rst_n = 1'b0; a_r = 64'd3; b_r = 64'd3;
        @(posedge clk); #1;
        check("reset_discards", got[1], 18'd0);
        rst_n = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1;
        check("idle_after_reset", got[1], 18'd0);
        in_valid = 1'b1; a_r = 64'd1; b_r = 64'd0;
        @(posedge clk); #1;
        check("first_after_reset", got[1], {5'b10000, 13'd1});

        rst_n = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) exp_h[k] = 18'd0;

        for (int n = 0; n < 10000; n++) begin
            a_r = {$urandom, $urandom}; b_r = {$urandom, $urandom};
            cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
            in_valid = ($urandom_range(0, 7) != 0);
            if (n % 16 == 0) begin
                a_r = '1; b_r = '0; cin = 1'b1; sub = 1'b0;
            end
            for (int k = 0; k < 5; k++) begin
                if (in_valid) exp_h[k] = model(wl[k], a_r, b_r, cin, SUB_EN & sub);
                else exp_h[k][17] = 1'b0;
            end
            @(posedge clk); #1;
            for (int k = 0; k < 5; k++) check($sformatf("rand_w%0d_n%0d", wl[k], n), got[k], exp_h[k]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
